// File: rtl/volume_octave_ctrl.sv
// volume_octave_ctrl: synchronizes, debounces and edge-detects four push-buttons that step saturating volume/octave.
// Optional hold-to-repeat stepping is enabled by defining VOLUME_OCTAVE_AUTO_REPEAT_EN.
module volume_octave_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int VOL_MIN         = 0,
    parameter int VOL_MAX         = 5,
    parameter int VOL_INIT        = 3,
    parameter int OCT_MIN         = 1,
    parameter int OCT_MAX         = 3,
    parameter int OCT_INIT        = 2,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_vol_up,
    input  logic       btn_vol_down,
    input  logic       btn_oct_up,
    input  logic       btn_oct_down,
    output logic [2:0] volume,
    output logic [2:0] octave,
    output logic       changed
);

    localparam int NUM_BTN      = 4;
    localparam int BTN_VOL_UP   = 0;
    localparam int BTN_VOL_DOWN = 1;
    localparam int BTN_OCT_UP   = 2;
    localparam int BTN_OCT_DOWN = 3;

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] VOL_MIN_C  = 3'(VOL_MIN);
    localparam logic [2:0] VOL_MAX_C  = 3'(VOL_MAX);
    localparam logic [2:0] VOL_INIT_C = 3'(VOL_INIT);
    localparam logic [2:0] OCT_MIN_C  = 3'(OCT_MIN);
    localparam logic [2:0] OCT_MAX_C  = 3'(OCT_MAX);
    localparam logic [2:0] OCT_INIT_C = 3'(OCT_INIT);

    // Reject configurations whose counters or bounds cannot work as intended.
    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        VOL_MIN > VOL_MAX || VOL_MAX > 7 || VOL_INIT < VOL_MIN || VOL_INIT > VOL_MAX ||
        OCT_MIN > OCT_MAX || OCT_MAX > 7 || OCT_INIT < OCT_MIN || OCT_INIT > OCT_MAX) begin : g_bad_cfg
        $error("volume_octave_ctrl: illegal parameter set");
    end

    // Saturating one-step update; bounds are checked before stepping so 3-bit arithmetic never wraps.
    function automatic logic [2:0] step_sat(
        input logic [2:0] cur,
        input logic       up,
        input logic       dn,
        input logic [2:0] lo,
        input logic [2:0] hi
    );
        logic [2:0] nxt;
        case ({up, dn})
            2'b10:   nxt = (cur < hi) ? (cur + 3'd1) : cur;
            2'b01:   nxt = (cur > lo) ? (cur - 3'd1) : cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    logic [NUM_BTN-1:0] btn_raw_s;
    logic [NUM_BTN-1:0] pulse_s;

    assign btn_raw_s = {btn_oct_down, btn_oct_up, btn_vol_down, btn_vol_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic             sync0_r;
        logic             sync1_r;
        logic             db_r;
        logic             db_q_r;
        logic [CNT_W-1:0] cnt_r;
        logic             rep_pulse_s;

        // Two-flop synchronizer for the raw asynchronous button level.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync0_r <= 1'b0;
                sync1_r <= 1'b0;
            end else begin
                sync0_r <= btn_raw_s[i];
                sync1_r <= sync0_r;
            end
        end

        // Debouncer: db follows sync1 only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk) begin
            if (rst) begin
                db_r   <= 1'b0;
                db_q_r <= 1'b0;
                cnt_r  <= '0;
            end else begin
                db_q_r <= db_r;
                if (sync1_r == db_r) begin
                    cnt_r <= '0;
                end else if (cnt_r == CNT_LAST) begin
                    db_r  <= ~db_r;
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end

`ifdef VOLUME_OCTAVE_AUTO_REPEAT_EN
        localparam int                HOLD_W    = $clog2(HOLD_CYCLES + REPEAT_CYCLES + 1);
        localparam logic [HOLD_W-1:0] HOLD_AT   = HOLD_W'(HOLD_CYCLES);
        localparam logic [HOLD_W-1:0] HOLD_WRAP = HOLD_W'(HOLD_CYCLES + REPEAT_CYCLES - 1);

        logic [HOLD_W-1:0] hold_cnt_r;

        // Hold timer: counts cycles of db high, then loops over the repeat period without overflowing.
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_cnt_r <= '0;
            end else if (!db_r) begin
                hold_cnt_r <= '0;
            end else if (hold_cnt_r == HOLD_WRAP) begin
                hold_cnt_r <= HOLD_AT;
            end else begin
                hold_cnt_r <= hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
            end
        end

        assign rep_pulse_s = db_r && (hold_cnt_r == HOLD_AT);
`else
        assign rep_pulse_s = 1'b0;
`endif

        assign pulse_s[i] = (db_r & ~db_q_r) | rep_pulse_s;
    end

    logic [2:0] volume_r;
    logic [2:0] octave_r;
    logic [2:0] volume_prev_r;
    logic [2:0] octave_prev_r;
    logic       changed_r;
    logic [2:0] vol_next_s;
    logic [2:0] oct_next_s;

    // Next register values from this cycle's pulses.
    always_comb begin
        vol_next_s = step_sat(volume_r, pulse_s[BTN_VOL_UP], pulse_s[BTN_VOL_DOWN], VOL_MIN_C, VOL_MAX_C);
        oct_next_s = step_sat(octave_r, pulse_s[BTN_OCT_UP], pulse_s[BTN_OCT_DOWN], OCT_MIN_C, OCT_MAX_C);
    end

    // Value registers plus a one-cycle-delayed copy; changed fires the cycle after a real difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            volume_r      <= VOL_INIT_C;
            octave_r      <= OCT_INIT_C;
            volume_prev_r <= VOL_INIT_C;
            octave_prev_r <= OCT_INIT_C;
            changed_r     <= 1'b0;
        end else begin
            volume_r      <= vol_next_s;
            octave_r      <= oct_next_s;
            volume_prev_r <= volume_r;
            octave_prev_r <= octave_r;
            changed_r     <= (volume_r != volume_prev_r) || (octave_r != octave_prev_r);
        end
    end

    assign volume  = volume_r;
    assign octave  = octave_r;
    assign changed = changed_r;

endmodule
